// File: rtl/arb2_rr_sel_pkg.sv
// Shared definitions for the two-channel round-robin mux-select arbiter.
package arb2_rr_sel_pkg;

  localparam int unsigned MAX_HOLD_DEF = 8;
  localparam int unsigned HOLD_W_DEF   = 8;

  // The grant states are one-hot, so the state register doubles as gnt.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_G0   = 2'b01,
    ST_G1   = 2'b10
  } state_e;

  // Grant state that belongs to a channel index.
  function automatic state_e grant_st(input logic idx);
    return idx ? ST_G1 : ST_G0;
  endfunction

endpackage

// File: rtl/arb2_rr_sel_hold_counter.sv
// Clearable, saturating up-counter with a terminal-count flag.
// Measures how long the current owner has held the grant.
module arb2_rr_sel_hold_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;

  // Clear wins over count; stop at the limit so tc stays asserted.
  always_ff @(posedge clk) begin
    if (!rst_n)                      cnt_q <= '0;
    else if (clr_i)                  cnt_q <= '0;
    else if (en_i && !(cnt_q == limit_i)) cnt_q <= cnt_q + 1'b1;
  end

  assign tc_o = (cnt_q == limit_i);

endmodule

// File: rtl/arb2_rr_sel.sv
// Two-channel round-robin arbiter driving the select of the downstream 2:1 mux.
// A hold timeout forces rotation when the other channel has been waiting.
module arb2_rr_sel
  import arb2_rr_sel_pkg::*;
#(
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEF,
  parameter int unsigned HOLD_W   = HOLD_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       done,
  output logic [1:0] gnt,
  output logic       sel,
  output logic       busy,
  output logic       preempt
);

  state_e state_q, state_d;
  logic   last_q, last_d;     // last-served channel; 1 after reset so ch0 wins ties
  logic   sel_q, sel_d;
  logic   pre_q, pre_d;
  logic   load;               // entering (or re-entering) a grant this cycle
  logic   nxt_idx;
  logic   cur, oth, tc;

  assign cur = (state_q == ST_G1);
  assign oth = ~cur;

  arb2_rr_sel_hold_counter #(.W(HOLD_W)) u_hold (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (load),
    .en_i    (state_q != ST_IDLE),
    .limit_i (HOLD_W'(MAX_HOLD - 1)),
    .tc_o    (tc)
  );

  // State register plus the registered side outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      pre_q   <= pre_d;
    end
  end

  // Next-state: release (done or abandon) beats timeout; no idle bubble on handover.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    pre_d   = 1'b0;
    load    = 1'b0;
    nxt_idx = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req != 2'b00) begin
          load    = 1'b1;
          nxt_idx = (req == 2'b11) ? ~last_q : req[1];
        end
      end
      ST_G0, ST_G1: begin
        if (done || !req[cur]) begin
          last_d = cur;
          if (req[oth]) begin
            load    = 1'b1;
            nxt_idx = oth;
          end else if (req[cur]) begin
            load    = 1'b1;
            nxt_idx = cur;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (tc && req[oth]) begin
          last_d  = cur;
          load    = 1'b1;
          nxt_idx = oth;
          pre_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load) begin
      state_d = grant_st(nxt_idx);
      sel_d   = nxt_idx;
    end
  end

  // Outputs come straight from flops; one-hot state encoding is the grant.
  always_comb begin
    gnt     = state_q;
    busy    = (state_q != ST_IDLE);
    sel     = sel_q;
    preempt = pre_q;
  end

endmodule

// File: tb/tb_arb2_rr_sel.sv
// Scoreboard bench for arb2_rr_sel: the driver predicts each cycle's outputs
// from a behavioural model; a monitor compares after every rising edge.
module tb_arb2_rr_sel;

  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req = 2'b00;
  logic       done = 1'b0;
  logic [1:0] gnt;
  logic       sel, busy, preempt;

  arb2_rr_sel dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt), .sel(sel), .busy(busy), .preempt(preempt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] gnt;
    logic       sel;
    logic       busy;
    logic       preempt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   preempt_seen = 0;

  // Reference model: owner -1 = idle; held = grant cycles completed by owner.
  int m_owner = -1;
  int m_last  = 1;
  int m_held  = 0;
  int m_sel   = 0;
  int m_pre   = 0;

  function automatic void model_grant(input int ch);
    m_owner = ch;
    m_sel   = ch;
    m_held  = 1;
  endfunction

  function automatic void model_step(input logic r_n, input logic [1:0] r, input logic d);
    int o;
    if (!r_n) begin
      m_owner = -1; m_last = 1; m_held = 0; m_sel = 0; m_pre = 0;
      return;
    end
    m_pre = 0;
    if (m_owner < 0) begin
      if (r == 2'b01)      model_grant(0);
      else if (r == 2'b10) model_grant(1);
      else if (r == 2'b11) model_grant(1 - m_last);
    end else begin
      o = 1 - m_owner;
      if (d || !r[m_owner]) begin
        m_last = m_owner;
        if (r[o])            model_grant(o);
        else if (r[m_owner]) model_grant(m_owner);
        else                 m_owner = -1;
      end else if (m_held >= MAX_HOLD && r[o]) begin
        m_last = m_owner;
        model_grant(o);
        m_pre = 1;
      end else begin
        m_held++;
      end
    end
  endfunction

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input logic r_n, input logic [1:0] r, input logic d);
    exp_t e;
    @(negedge clk);
    rst_n = r_n; req = r; done = d;
    model_step(r_n, r, d);
    e.gnt     = (m_owner < 0) ? 2'b00 : 2'(1 << m_owner);
    e.sel     = m_sel[0];
    e.busy    = (m_owner >= 0);
    e.preempt = m_pre[0];
    exp_q.push_back(e);
  endtask

  task automatic cmp(input string name, input logic [1:0] act, input logic [1:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", name, cyc, act, expv);
    end
  endtask

  // Monitor: outputs are valid every cycle, compare just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        cmp("gnt",     gnt,            e.gnt);
        cmp("sel",     {1'b0, sel},    {1'b0, e.sel});
        cmp("busy",    {1'b0, busy},   {1'b0, e.busy});
        cmp("preempt", {1'b0, preempt}, {1'b0, e.preempt});
        if (preempt === 1'b1) preempt_seen++;
      end
    end
  end

  initial begin
    int pre_before;
    // 1: reset then a single request and done
    step(0, 2'b00, 0); step(0, 2'b00, 0);
    step(1, 2'b01, 0); step(1, 2'b01, 1); step(1, 2'b00, 0);
    // 2: ties alternate with no idle bubble
    step(1, 2'b11, 0); step(1, 2'b11, 1); step(1, 2'b11, 0);
    step(1, 2'b11, 1); step(1, 2'b00, 1); step(1, 2'b00, 0);
    // 3: timeout from a fresh reset, G0 held 8 cycles then preempted to G1
    step(0, 2'b00, 0);
    repeat (12) step(1, 2'b11, 0);
    step(1, 2'b00, 0);
    // 4: lone requester never preempted
    pre_before = preempt_seen;
    repeat (20) step(1, 2'b01, 0);
    step(1, 2'b00, 0); step(1, 2'b00, 0);
    checks++;
    if (preempt_seen != pre_before) begin
      failures++;
      $display("FAIL no_starve_preempt got=%0d exp=0", preempt_seen - pre_before);
    end
    // 5: done on the timeout cycle suppresses preempt
    step(0, 2'b00, 0);
    step(1, 2'b11, 0);
    repeat (7) step(1, 2'b11, 0);
    step(1, 2'b11, 1);
    step(1, 2'b10, 1); step(1, 2'b00, 0);
    // 6: abandon from G1, mid-grant reset, then tie
    step(1, 2'b10, 0); step(1, 2'b10, 0); step(1, 2'b00, 0);
    step(1, 2'b10, 0); step(1, 2'b10, 0); step(0, 2'b10, 0);
    step(1, 2'b11, 0); step(1, 2'b11, 0);
    // Random phase: sticky requests, rare done, occasional reset
    begin
      logic [1:0] r = 2'b11;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(3) == 0) r = 2'($urandom_range(3));
        step(($urandom_range(199) != 0), r, ($urandom_range(11) == 0));
      end
    end
    step(0, 2'b00, 0);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d exp=0", exp_q.size());
    end
    checks++;
    if (preempt_seen == 0) begin
      failures++;
      $display("FAIL preempt_coverage got=0 exp=nonzero");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
